// File: rtl/reset_sequencer_if.sv
// Reset-sequencer side-band bundle: lock/request inputs and the staged reset outputs.
// master = the sequencer, slave = the clock manager / system-control environment.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   locked;
    logic                   sw_reset_req;
    logic                   pll_reset;
    logic [NUM_DOMAINS-1:0] domain_reset;
    logic                   ready;
    logic                   lock_lost;
    logic [3:0]             retry_count;
    logic [2:0]             state;

    modport master (
        input  locked, sw_reset_req,
        output pll_reset, domain_reset, ready, lock_lost, retry_count, state
    );

    modport slave (
        output locked, sw_reset_req,
        input  pll_reset, domain_reset, ready, lock_lost, retry_count, state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Clock-manager reset, filtered lock acquisition with timeout retry, then staged
// per-domain reset release in index order; lock loss or a software request re-sequences.
module reset_sequencer #(
    parameter int NUM_DOMAINS      = 4,
    parameter int PLL_RESET_CYCLES = 8,
    parameter int LOCK_FILTER      = 4,
    parameter int LOCK_TIMEOUT     = 1000,
    parameter int HOLD_CYCLES      = 16,
    parameter int STAGE_CYCLES     = 8,
    parameter int CNT_WIDTH        = 10
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   filt_q, filt_d;
    logic [1:0]             lsync_q, lsync_d;
    logic                   pll_reset_q, pll_reset_d;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [3:0]             retry_q, retry_d;

    logic locked_sync;
    logic sw_go;
    logic lock_drop;
    logic timeout;
    logic release_step;
    logic last_step;

    assign lsync_d     = {lsync_q[0], bus.locked};
    assign locked_sync = lsync_q[1];
    // The next release shift empties the vector: this step frees the last domain.
    assign last_step   = ((domain_reset_q << 1) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PLL_RST;
            cnt_q          <= '0;
            filt_q         <= '0;
            lsync_q        <= '0;
            pll_reset_q    <= 1'b1;
            domain_reset_q <= '1;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
            retry_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            filt_q         <= filt_d;
            lsync_q        <= lsync_d;
            pll_reset_q    <= pll_reset_d;
            domain_reset_q <= domain_reset_d;
            ready_q        <= ready_d;
            lock_lost_q    <= lock_lost_d;
            retry_q        <= retry_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        filt_d       = '0;
        sw_go        = 1'b0;
        lock_drop    = 1'b0;
        timeout      = 1'b0;
        release_step = 1'b0;
        if (bus.sw_reset_req && (state_q != PLL_RST)) begin
            sw_go   = 1'b1;
            state_d = PLL_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == CNT_WIDTH'(PLL_RESET_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    filt_d = locked_sync ? (filt_q + CNT_ONE) : '0;
                    // A lock completing on the timeout edge is still accepted.
                    if (locked_sync && (filt_q == CNT_WIDTH'(LOCK_FILTER - 1))) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end else if (cnt_q == CNT_WIDTH'(LOCK_TIMEOUT - 1)) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                        filt_d  = '0;
                        timeout = 1'b1;
                    end
                end
                HOLD, RELEASE, RUN: begin
                    if (!locked_sync) begin
                        state_d   = WAIT_LOCK;
                        cnt_d     = '0;
                        lock_drop = 1'b1;
                    end else if (state_q == HOLD) begin
                        if (cnt_q == CNT_WIDTH'(HOLD_CYCLES - 1)) begin
                            release_step = 1'b1;
                            cnt_d        = '0;
                            state_d      = (NUM_DOMAINS == 1) ? RUN : RELEASE;
                        end
                    end else if (state_q == RELEASE) begin
                        if (cnt_q == CNT_WIDTH'(STAGE_CYCLES - 1)) begin
                            release_step = 1'b1;
                            cnt_d        = '0;
                            if (last_step) state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pll_reset_d    = (state_d == PLL_RST);
        ready_d        = (state_d == RUN);
        domain_reset_d = domain_reset_q;
        if (state_d inside {PLL_RST, WAIT_LOCK, HOLD}) begin
            domain_reset_d = '1;
        end else if (release_step) begin
            domain_reset_d = domain_reset_q << 1;
        end
        lock_lost_d = lock_lost_q;
        if (sw_go) begin
            lock_lost_d = 1'b0;
        end else if (lock_drop && (state_q == RUN)) begin
            lock_lost_d = 1'b1;
        end
        retry_d = retry_q;
        if (timeout && (retry_q != 4'hF)) retry_d = retry_q + 4'd1;
    end

    assign bus.pll_reset    = pll_reset_q;
    assign bus.domain_reset = domain_reset_q;
    assign bus.ready        = ready_q;
    assign bus.lock_lost    = lock_lost_q;
    assign bus.retry_count  = retry_q;
    assign bus.state        = state_q;
endmodule
